// File: rtl/csr_scrub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_scrub_ctrl_pkg
// Description : Shared types and constants for the CSR scrub sequencer.
//               - scrub_fsm          : sequencer state encoding
//               - c_MCSR_*           : machine-CSR index map shared with the CSR unit
//               - SCRUB_SKIP_DEFAULT : indices that must never be rewritten
//                                      (free-running counters, constant CSRs)
//               - sat_inc8           : saturating 8-bit increment
// Revision    : 1.0 - initial release
// ============================================================================
package csr_scrub_ctrl_pkg;

    typedef enum logic [2:0] {
        SCRUB_IDLE  = 3'd0,
        SCRUB_WAIT  = 3'd1,
        SCRUB_READ  = 3'd2,
        SCRUB_WRITE = 3'd3,
        SCRUB_NEXT  = 3'd4
    } scrub_fsm;

    // Machine-CSR index space
    localparam int unsigned c_MCSR_STATUS   = 0;
    localparam int unsigned c_MCSR_ISA      = 1;
    localparam int unsigned c_MCSR_IE       = 2;
    localparam int unsigned c_MCSR_TVEC     = 3;
    localparam int unsigned c_MCSR_SCRATCH  = 4;
    localparam int unsigned c_MCSR_EPC      = 5;
    localparam int unsigned c_MCSR_CAUSE    = 6;
    localparam int unsigned c_MCSR_TVAL     = 7;
    localparam int unsigned c_MCSR_IP       = 8;
    localparam int unsigned c_MCSR_HARTID   = 9;
    localparam int unsigned c_MCSR_CYCLE    = 10;
    localparam int unsigned c_MCSR_INSTRET  = 11;
    localparam int unsigned c_MCSR_CYCLEH   = 12;
    localparam int unsigned c_MCSR_INSTRETH = 13;
    localparam int unsigned c_MCSR_HRDCTRL  = 14;

    // Counters change every cycle and ISA/HARTID are constants, so a
    // rewrite would either race the hardware update or do nothing useful.
    localparam logic [14:0] SCRUB_SKIP_DEFAULT =
          (15'd1 << c_MCSR_CYCLE)   | (15'd1 << c_MCSR_CYCLEH)
        | (15'd1 << c_MCSR_INSTRET) | (15'd1 << c_MCSR_INSTRETH)
        | (15'd1 << c_MCSR_HARTID)  | (15'd1 << c_MCSR_ISA);

    function automatic logic [7:0] sat_inc8(input logic [7:0] i_val);
        return (i_val == 8'hFF) ? i_val : i_val + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_scrub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_scrub_ctrl_if
// Description : Bus between the scrub sequencer and the CSR unit.
//               master : scrub sequencer side
//               slave  : CSR unit / control side
//               s_en_i, s_pipe_req_i, s_rd_data_i, s_mismatch_i : into sequencer
//               s_scrub_idx_o, s_scrub_we_o, s_scrub_wdata_o,
//               s_busy_o, s_done_o, s_err_cnt_o                 : out of sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_scrub_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             s_en_i;
    logic             s_pipe_req_i;
    logic [31:0]      s_rd_data_i;
    logic             s_mismatch_i;
    logic [IDX_W-1:0] s_scrub_idx_o;
    logic             s_scrub_we_o;
    logic [31:0]      s_scrub_wdata_o;
    logic             s_busy_o;
    logic             s_done_o;
    logic [7:0]       s_err_cnt_o;

    modport master (
        input  s_en_i, s_pipe_req_i, s_rd_data_i, s_mismatch_i,
        output s_scrub_idx_o, s_scrub_we_o, s_scrub_wdata_o,
               s_busy_o, s_done_o, s_err_cnt_o
    );

    modport slave (
        output s_en_i, s_pipe_req_i, s_rd_data_i, s_mismatch_i,
        input  s_scrub_idx_o, s_scrub_we_o, s_scrub_wdata_o,
               s_busy_o, s_done_o, s_err_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/csr_scrub_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : csr_scrub_ctrl_timer
// Description : Loadable down-counter with zero flag that times the gap
//               between sweeps.
//               clk, rst : clock, synchronous active-high reset
//               i_load   : reload with PERIOD-1 (wins over i_dec)
//               i_dec    : decrement, holds at zero
//               o_zero   : counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module csr_scrub_ctrl_timer #(
    parameter int PERIOD = 1024,
    parameter int CNT_W  = $clog2(PERIOD)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_zero
);
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = c_RELOAD;
        end else if (i_dec && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= c_RELOAD;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/csr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_scrub_ctrl
// Description : Periodic scrubber for the triplicated machine CSRs. Sweeps
//               indices 0..N_CSR-1, rewrites the voted value into all
//               replicas of any CSR whose replicas disagree, and yields the
//               shared write port to the MA-stage pipeline at all times.
//               s_clk_i, s_rst_i : clock, synchronous active-high reset
//               bus (master)     : enable, pipeline request, voted data and
//                                  mismatch in; index, write strobe/data,
//                                  busy, done pulse, error count out
// Revision    : 1.0 - initial release
// ============================================================================
module csr_scrub_ctrl
    import csr_scrub_ctrl_pkg::*;
#(
    parameter int               N_CSR     = 15,
    parameter int               IDX_W     = 4,
    parameter int               PERIOD    = 1024,
    parameter logic [N_CSR-1:0] SKIP_MASK = '0
) (
    input  wire logic         s_clk_i,
    input  wire logic         s_rst_i,
    csr_scrub_ctrl_if.master  bus
);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_CSR - 1);

    scrub_fsm         r_state_q, w_state_d;
    logic [IDX_W-1:0] r_idx_q,   w_idx_d;
    logic [31:0]      r_wdata_q, w_wdata_d;
    logic [7:0]       r_err_q,   w_err_d;

    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_zero;
    logic w_last;
    logic w_skip;

    csr_scrub_ctrl_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (s_clk_i),
        .rst    (s_rst_i),
        .i_load (w_tmr_load),
        .i_dec  (w_tmr_dec),
        .o_zero (w_tmr_zero)
    );

    assign w_last = (r_idx_q == c_LAST_IDX);
    assign w_skip = SKIP_MASK[r_idx_q];

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_wdata_d  = r_wdata_q;
        w_err_d    = r_err_q;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;

        if (!bus.s_en_i) begin
            // Abort: pending write dropped, error count kept.
            w_state_d = SCRUB_IDLE;
            w_idx_d   = '0;
        end else begin
            case (r_state_q)
                SCRUB_IDLE: begin
                    w_state_d  = SCRUB_WAIT;
                    w_tmr_load = 1'b1;
                end
                SCRUB_WAIT: begin
                    if (w_tmr_zero) begin
                        w_state_d = SCRUB_READ;
                        w_idx_d   = '0;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                SCRUB_READ: begin
                    if (w_skip) begin
                        w_state_d = SCRUB_NEXT;
                    end else if (bus.s_pipe_req_i) begin
                        w_state_d = SCRUB_READ;
                    end else if (bus.s_mismatch_i) begin
                        w_wdata_d = bus.s_rd_data_i;
                        w_state_d = SCRUB_WRITE;
                    end else begin
                        w_state_d = SCRUB_NEXT;
                    end
                end
                SCRUB_WRITE: begin
                    // A pipeline access may have modified the CSR, so the
                    // captured value is re-read instead of retried.
                    if (bus.s_pipe_req_i) begin
                        w_state_d = SCRUB_READ;
                    end else begin
                        w_err_d   = sat_inc8(r_err_q);
                        w_state_d = SCRUB_NEXT;
                    end
                end
                SCRUB_NEXT: begin
                    if (w_last) begin
                        w_idx_d    = '0;
                        w_state_d  = SCRUB_WAIT;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_idx_d   = r_idx_q + IDX_W'(1);
                        w_state_d = SCRUB_READ;
                    end
                end
                default: begin
                    w_state_d = SCRUB_IDLE;
                    w_idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            r_state_q <= SCRUB_IDLE;
            r_idx_q   <= '0;
            r_wdata_q <= '0;
            r_err_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_wdata_q <= w_wdata_d;
            r_err_q   <= w_err_d;
        end
    end

    // Write strobe yields to the pipeline in the same cycle and is
    // withheld when the sequencer is being disabled.
    assign bus.s_scrub_we_o    = (r_state_q == SCRUB_WRITE) && bus.s_en_i && !bus.s_pipe_req_i;
    assign bus.s_done_o        = (r_state_q == SCRUB_NEXT) && w_last && bus.s_en_i;
    assign bus.s_busy_o        = (r_state_q == SCRUB_READ) || (r_state_q == SCRUB_WRITE)
                              || (r_state_q == SCRUB_NEXT);
    assign bus.s_scrub_idx_o   = r_idx_q;
    assign bus.s_scrub_wdata_o = r_wdata_q;
    assign bus.s_err_cnt_o     = r_err_q;

endmodule
`default_nettype wire
